// File: rtl/audio_i2s_player.sv
// rtl/audio_i2s_player.sv - two-channel square-tone generator streaming 16-bit I2S frames to a DAC
// Clocks derive from one 9-bit divider; samples are latched once per frame so the serializer never sees mid-frame changes.
module audio_i2s_player #(
    parameter int MIN_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] note_div_left,
    input  logic [21:0] note_div_right,
    input  logic [15:0] amplitude,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin
);

    logic [8:0]  cnt;
    logic [21:0] tcnt_l;
    logic [21:0] tcnt_r;
    logic [15:0] amp_neg;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic [15:0] word_l;
    logic [15:0] word_r;
    logic        lsb_hold;
    logic [4:0]  slot_nxt;
    logic [3:0]  bit_idx;
    logic        sdin_nxt;

    // The >= compare lets a counter above a freshly shrunk divider wrap at once.
    function automatic logic [21:0] tone_next(input logic [21:0] t, input logic [21:0] d);
        if (d < 22'(MIN_DIV)) begin
            return '0;
        end else if (t >= d - 22'd1) begin
            return '0;
        end else begin
            return t + 22'd1;
        end
    endfunction

    function automatic logic [15:0] tone_sample(input logic [21:0] t, input logic [21:0] d,
                                                input logic [15:0] pos, input logic [15:0] neg);
        if (d < 22'(MIN_DIV)) begin
            return '0;
        end else if (t < (d >> 1)) begin
            return pos;
        end else begin
            return neg;
        end
    endfunction

    assign amp_neg  = 16'd0 - amplitude;
    assign sample_l = tone_sample(tcnt_l, note_div_left, amplitude, amp_neg);
    assign sample_r = tone_sample(tcnt_r, note_div_right, amplitude, amp_neg);

    assign audio_mclk = cnt[1];
    assign audio_sck  = cnt[3];
    assign audio_lrck = cnt[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            tcnt_l <= '0;
            tcnt_r <= '0;
        end else begin
            cnt    <= cnt + 9'd1;
            tcnt_l <= tone_next(tcnt_l, note_div_left);
            tcnt_r <= tone_next(tcnt_r, note_div_right);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_l   <= '0;
            word_r   <= '0;
            lsb_hold <= 1'b0;
        end else begin
            if (cnt == 9'd511) begin
                word_l <= sample_l;
                word_r <= sample_r;
            end
            // Right word's LSB is sent in the next frame's left slot 0, after word_r is overwritten.
            if (cnt == 9'd255) begin
                lsb_hold <= word_r[0];
            end
        end
    end

    // Slot/channel that begins at the coming sck falling edge; slot s carries bit 16-s.
    assign slot_nxt = cnt[8:4] + 5'd1;
    assign bit_idx  = 4'd0 - slot_nxt[3:0];

    always_comb begin
        sdin_nxt = 1'b0;
        if (slot_nxt[3:0] == 4'd0) begin
            sdin_nxt = slot_nxt[4] ? word_l[0] : lsb_hold;
        end else begin
            sdin_nxt = slot_nxt[4] ? word_r[bit_idx] : word_l[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            audio_sdin <= 1'b0;
        end else if (cnt[3:0] == 4'hF) begin
            audio_sdin <= sdin_nxt;
        end
    end

endmodule

// File: tb/tb_audio_i2s_player.sv
// tb/tb_audio_i2s_player.sv - self-checking bench for audio_i2s_player
// Expected I2S stream is built from per-frame words delayed by one bit slot.
module tb_audio_i2s_player;

    localparam int MIN_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] note_div_left = '0;
    logic [21:0] note_div_right = '0;
    logic [15:0] amplitude = '0;
    logic        audio_mclk;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdin;

    int errors = 0;
    int checks = 0;

    logic [15:0] wl[$];
    logic [15:0] wr[$];

    audio_i2s_player #(.MIN_DIV(MIN_DIV)) dut (
        .clk            (clk),
        .rst            (rst),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .amplitude      (amplitude),
        .audio_mclk     (audio_mclk),
        .audio_sck      (audio_sck),
        .audio_lrck     (audio_lrck),
        .audio_sdin     (audio_sdin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Sample a channel latches at a frame boundary, t = tone-counter value (clk cycles since reset mod div).
    function automatic logic [15:0] model_word(input int div, input logic [15:0] amp, input int t_total);
        int t;
        if (div < MIN_DIV) return 16'h0000;
        t = t_total % div;
        if (t < div / 2) return amp;
        return 16'((65536 - int'(amp)) % 65536);
    endfunction

    // Reset for 3 clk, apply a tone setup, then run nedges clk checking clocks, stream and latched words.
    task automatic run_seg(input string tag, input int dl, input int dr, input logic [15:0] amp,
                           input int nedges, input bit jitter);
        int g, j, f, k;
        logic [15:0] w;
        logic        exp_bit;
        rst = 1'b1;
        note_div_left  = 22'(dl);
        note_div_right = 22'(dr);
        amplitude      = amp;
        repeat (3) begin
            tick();
            check({tag, "_rst_outs"}, {28'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
        end
        rst = 1'b0;
        wl.delete();
        wr.delete();
        wl.push_back(16'h0000);
        wr.push_back(16'h0000);
        for (int n = 1; n <= nedges; n++) begin
            if (jitter && $urandom_range(0, 63) == 0) amplitude = 16'($urandom);
            if (n % 512 == 0) begin
                wl.push_back(model_word(dl, amplitude, n - 1));
                wr.push_back(model_word(dr, amplitude, n - 1));
            end
            tick();
            if (n == 1) check({tag, "_cnt_first"}, 32'(dut.cnt), 32'd1);
            check({tag, "_mclk"}, 32'(audio_mclk), 32'((n / 2) % 2));
            check({tag, "_sck"},  32'(audio_sck),  32'((n / 8) % 2));
            check({tag, "_lrck"}, 32'(audio_lrck), 32'((n / 256) % 2));
            g = n / 16;
            if (g == 0) begin
                exp_bit = 1'b0;
            end else begin
                j = g - 1;
                f = j / 32;
                k = j % 32;
                if (k < 16) begin
                    w = wl[f];
                    exp_bit = w[15 - k];
                end else begin
                    w = wr[f];
                    exp_bit = w[31 - k];
                end
            end
            check({tag, "_sdin"}, 32'(audio_sdin), 32'(exp_bit));
            if (n % 512 == 0) begin
                check({tag, "_word_l"}, 32'(dut.word_l), 32'(wl[n / 512]));
                check({tag, "_word_r"}, 32'(dut.word_r), 32'(wr[n / 512]));
            end
        end
    endtask

    initial begin
        int dl, dr;
        // Clock timing and silence (div 0 and div 1 are both below MIN_DIV)
        run_seg("silence", 0, 1, 16'h7FFF, 2048, 1'b0);
        // Serial frame with a 1000-cycle tone on both channels
        run_seg("frame1234", 1000, 1000, 16'h1234, 3 * 512, 1'b0);
        // Square wave: 4 frames per phase on the left
        run_seg("square", 4096, 3001, 16'h0100, 9 * 512, 1'b0);
        // Amplitude wrap cases and an odd small divider
        run_seg("amp8000", 3, 5, 16'h8000, 2 * 512, 1'b0);
        run_seg("amp0", 100, 2, 16'h0000, 2 * 512, 1'b0);
        // Abort mid-frame at cnt = 300, then restart cleanly
        run_seg("abort", 1000, 777, 16'hBEEF, 512 + 300, 1'b0);
        run_seg("post_abort", 1000, 777, 16'hBEEF, 3 * 512, 1'b0);
        // Random tones with amplitude changing mid-frame
        for (int i = 0; i < 4; i++) begin
            dl = int'($urandom_range(0, 5000));
            dr = int'($urandom_range(0, 5000));
            run_seg("random", dl, dr, 16'($urandom), 4 * 512, 1'b1);
        end
        // Mid-tone shrink of the left divider
        run_seg("shrink_pre", 4000, 4000, 16'h1111, 3000, 1'b0);
        check("shrink_tcnt_3000", 32'(dut.tcnt_l), 32'd3000);
        note_div_left = 22'd1000;
        tick();
        check("shrink_wrap", 32'(dut.tcnt_l), 32'd0);
        repeat (999) tick();
        check("shrink_999", 32'(dut.tcnt_l), 32'd999);
        tick();
        check("shrink_period", 32'(dut.tcnt_l), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
